// File: rtl/elevator_plant_if.sv
// rtl/elevator_plant_if.sv - actuator/sensor bundle between controller (master) and plant (slave)
interface elevator_plant_if;
  logic [1:0] motor;
  logic [1:0] puertas;
  logic       obstaculo;
  logic       cambio_piso;
  logic [1:0] estado_puertas;
  logic       sensor_puertas;
  logic [1:0] piso;
  logic       interlock_fault;
  logic       overtravel_fault;
  logic       cmd_fault;

  modport master (
    output motor, puertas, obstaculo,
    input  cambio_piso, estado_puertas, sensor_puertas, piso,
           interlock_fault, overtravel_fault, cmd_fault
  );
  modport slave (
    input  motor, puertas, obstaculo,
    output cambio_piso, estado_puertas, sensor_puertas, piso,
           interlock_fault, overtravel_fault, cmd_fault
  );
endinterface

// File: rtl/elevator_plant.sv
// rtl/elevator_plant.sv - cabin and door plant model answering motor/puertas commands
module elevator_plant #(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 4,
  parameter int INIT_FLOOR  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  elevator_plant_if.slave  bus
);
  localparam int TW = $clog2(FLOOR_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS);

  typedef enum logic [1:0] {M_IDLE, M_UP, M_DOWN} mot_t;
  typedef enum logic [1:0] {
    D_CLOSED = 2'b00, D_OPENING = 2'b01, D_OPEN = 2'b10, D_CLOSING = 2'b11
  } door_t;

  mot_t          mot_q, mot_d;
  door_t         door_q, door_d;
  logic [TW-1:0] trav_q, trav_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [1:0]    piso_q, piso_d;
  logic          pulse_q, pulse_d;
  logic          sens_q, sens_d;
  logic          il_q, il_d, ov_q, ov_d, cmd_q, cmd_d;

  logic up, dn, p_open, p_close;
  assign up      = (bus.motor == 2'b01);
  assign dn      = (bus.motor == 2'b10);
  assign p_open  = (bus.puertas == 2'b01);
  assign p_close = (bus.puertas == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mot_q   <= M_IDLE;
      door_q  <= D_CLOSED;
      trav_q  <= '0;
      dcnt_q  <= '0;
      piso_q  <= 2'(INIT_FLOOR);
      pulse_q <= 1'b0;
      sens_q  <= 1'b0;
      il_q    <= 1'b0;
      ov_q    <= 1'b0;
      cmd_q   <= 1'b0;
    end else begin
      mot_q   <= mot_d;
      door_q  <= door_d;
      trav_q  <= trav_d;
      dcnt_q  <= dcnt_d;
      piso_q  <= piso_d;
      pulse_q <= pulse_d;
      sens_q  <= sens_d;
      il_q    <= il_d;
      ov_q    <= ov_d;
      cmd_q   <= cmd_d;
    end
  end

  // Motion: the counter holds consecutive enabled edges in one direction, so a
  // reversal or stop discards progress and the reversal edge counts as the first.
  always_comb begin
    mot_d   = M_IDLE;
    trav_d  = '0;
    piso_d  = piso_q;
    pulse_d = 1'b0;
    if (door_q == D_CLOSED && up && piso_q != 2'd3) begin
      mot_d  = M_UP;
      trav_d = (mot_q == M_UP) ? trav_q + TW'(1) : TW'(1);
    end else if (door_q == D_CLOSED && dn && piso_q != 2'd0) begin
      mot_d  = M_DOWN;
      trav_d = (mot_q == M_DOWN) ? trav_q + TW'(1) : TW'(1);
    end
    if (mot_d != M_IDLE && trav_d == TW'(FLOOR_TICKS)) begin
      trav_d  = '0;
      pulse_d = 1'b1;
      piso_d  = (mot_d == M_UP) ? piso_q + 2'd1 : piso_q - 2'd1;
    end
  end

  always_comb begin
    door_d = door_q;
    dcnt_d = dcnt_q;
    case (door_q)
      D_CLOSED: begin
        if (p_open && !(up || dn)) begin
          door_d = D_OPENING;
          dcnt_d = '0;
        end
      end
      D_OPENING: begin
        if (p_close) begin
          door_d = D_CLOSING;
          dcnt_d = '0;
        end else if (dcnt_q == DW'(DOOR_TICKS - 1)) begin
          door_d = D_OPEN;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      D_OPEN: begin
        if (p_close && !bus.obstaculo) begin
          door_d = D_CLOSING;
          dcnt_d = '0;
        end
      end
      default: begin
        // Reopening beats stroke completion so an obstacle at the last tick still reopens.
        if (bus.obstaculo || p_open) begin
          door_d = D_OPENING;
          dcnt_d = '0;
        end else if (dcnt_q == DW'(DOOR_TICKS - 1)) begin
          door_d = D_CLOSED;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
    endcase
  end

  always_comb begin
    sens_d = bus.obstaculo && (door_q != D_CLOSED);
    cmd_d  = cmd_q | (bus.motor == 2'b11) | (bus.puertas == 2'b11);
    ov_d   = ov_q | (up && piso_q == 2'd3) | (dn && piso_q == 2'd0);
    il_d   = il_q | ((up || dn) && door_q != D_CLOSED) | (p_open && (up || dn));
  end

  assign bus.cambio_piso      = pulse_q;
  assign bus.estado_puertas   = door_q;
  assign bus.sensor_puertas   = sens_q;
  assign bus.piso             = piso_q;
  assign bus.interlock_fault  = il_q;
  assign bus.overtravel_fault = ov_q;
  assign bus.cmd_fault        = cmd_q;
endmodule

// File: tb/tb_elevator_plant.sv
// tb/tb_elevator_plant.sv - directed scenarios plus randomized run against a cycle model
module tb_elevator_plant;
  localparam int FT = 8;
  localparam int DT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  elevator_plant_if bus ();
  elevator_plant #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT), .INIT_FLOOR(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: floor, door phase (0 closed,1 opening,2 open,3 closing), elapsed ticks.
  int m_floor, m_ticks, m_dir, m_door, m_dcnt;
  int m_pulse, m_sens, m_il, m_ov, m_cmd;

  task automatic model_reset();
    m_floor = 0; m_ticks = 0; m_dir = 0; m_door = 0; m_dcnt = 0;
    m_pulse = 0; m_sens = 0; m_il = 0; m_ov = 0; m_cmd = 0;
  endtask

  task automatic model_step(input int mo, input int pu, input int ob);
    int want, old_door;
    bit go_up, go_dn, moving;
    go_up = (mo == 1);
    go_dn = (mo == 2);
    moving = go_up || go_dn;
    old_door = m_door;
    if (mo == 3 || pu == 3) m_cmd = 1;
    if ((go_up && m_floor == 3) || (go_dn && m_floor == 0)) m_ov = 1;
    if (moving && old_door != 0) m_il = 1;
    if (pu == 1 && moving) m_il = 1;
    want = 0;
    if (old_door == 0 && go_up && m_floor < 3) want = 1;
    if (old_door == 0 && go_dn && m_floor > 0) want = -1;
    m_pulse = 0;
    if (want == 0) begin
      m_ticks = 0;
    end else begin
      m_ticks = (want == m_dir) ? m_ticks + 1 : 1;
      if (m_ticks == FT) begin
        m_floor += want;
        m_ticks = 0;
        m_pulse = 1;
      end
    end
    m_dir = want;
    m_sens = (ob != 0 && old_door != 0) ? 1 : 0;
    case (old_door)
      0: if (pu == 1 && !moving) begin m_door = 1; m_dcnt = 0; end
      1: if (pu == 2) begin m_door = 3; m_dcnt = 0; end
         else if (m_dcnt == DT - 1) begin m_door = 2; m_dcnt = 0; end
         else m_dcnt++;
      2: if (pu == 2 && ob == 0) begin m_door = 3; m_dcnt = 0; end
      default: if (ob != 0 || pu == 1) begin m_door = 1; m_dcnt = 0; end
         else if (m_dcnt == DT - 1) begin m_door = 0; m_dcnt = 0; end
         else m_dcnt++;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step(int'(bus.motor), int'(bus.puertas), int'(bus.obstaculo));
  end

  always @(negedge clk) begin
    logic [9:0] act, exp;
    act = {bus.piso, bus.estado_puertas, bus.cambio_piso, bus.sensor_puertas,
           bus.interlock_fault, bus.overtravel_fault, bus.cmd_fault, 1'b0};
    exp = {m_floor[1:0], m_door[1:0], m_pulse[0], m_sens[0], m_il[0], m_ov[0], m_cmd[0], 1'b0};
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t: got piso/door/pulse/sens/il/ov/cmd=%b required %b",
               $time, act[9:1], exp[9:1]);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] mo, input logic [1:0] pu, input logic ob);
    bus.motor = mo;
    bus.puertas = pu;
    bus.obstaculo = ob;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int pe[$];
    int n, npulse;
    bit hold_obs;
    logic [1:0] rm, rp;
    bus.motor = 2'b00;
    bus.puertas = 2'b00;
    bus.obstaculo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_piso", int'(bus.piso), 0);
    chk("reset_door", int'(bus.estado_puertas), 0);
    chk("reset_faults", int'({bus.interlock_fault, bus.overtravel_fault, bus.cmd_fault}), 0);
    rst_n = 1'b1;

    // Continuous up from floor 0
    for (int e = 1; e <= 26; e++) begin
      step(2'b01, 2'b00, 1'b0);
      if (bus.cambio_piso) pe.push_back(e);
      if (e == 24) chk("t1_ov_before", int'(bus.overtravel_fault), 0);
      if (e == 25) chk("t1_ov_after", int'(bus.overtravel_fault), 1);
    end
    chk("t1_npulse", pe.size(), 3);
    if (pe.size() == 3) begin
      chk("t1_pulse0", pe[0], 8);
      chk("t1_pulse1", pe[1], 16);
      chk("t1_pulse2", pe[2], 24);
    end
    chk("t1_piso", int'(bus.piso), 3);

    // Stop mid-travel discards progress
    do_reset();
    repeat (5) step(2'b01, 2'b00, 1'b0);
    repeat (2) step(2'b00, 2'b00, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(2'b01, 2'b00, 1'b0);
      n++;
      if (bus.cambio_piso) break;
    end
    chk("t2_restart_edges", n, 8);
    chk("t2_piso", int'(bus.piso), 1);

    // Open at floor 1, then motion attempt while open
    step(2'b00, 2'b01, 1'b0);
    n = 0;
    for (int i = 0; i < 10 && bus.estado_puertas == 2'b01; i++) begin
      n++;
      step(2'b00, 2'b00, 1'b0);
    end
    chk("t3_opening_cycles", n, 4);
    chk("t3_open", int'(bus.estado_puertas), 2);
    step(2'b10, 2'b00, 1'b0);
    chk("t3_piso_hold", int'(bus.piso), 1);
    chk("t3_interlock", int'(bus.interlock_fault), 1);

    // Obstacle on second closing cycle reopens
    step(2'b00, 2'b10, 1'b0);
    chk("t4_closing1", int'(bus.estado_puertas), 3);
    step(2'b00, 2'b00, 1'b0);
    chk("t4_closing2", int'(bus.estado_puertas), 3);
    step(2'b00, 2'b00, 1'b1);
    chk("t4_reopen", int'(bus.estado_puertas), 1);
    chk("t4_sensor", int'(bus.sensor_puertas), 1);
    n = 0;
    for (int i = 0; i < 10 && bus.estado_puertas == 2'b01; i++) begin
      n++;
      step(2'b00, 2'b00, 1'b0);
    end
    chk("t4_reopen_cycles", n, 4);
    chk("t4_open", int'(bus.estado_puertas), 2);

    // Illegal encodings
    step(2'b11, 2'b00, 1'b0);
    chk("t5_cmd_fault", int'(bus.cmd_fault), 1);
    chk("t5_piso", int'(bus.piso), 1);
    step(2'b00, 2'b11, 1'b0);
    chk("t5_door_hold", int'(bus.estado_puertas), 2);

    // Async reset mid-opening
    step(2'b00, 2'b10, 1'b0);
    repeat (4) step(2'b00, 2'b00, 1'b0);
    chk("t5_closed", int'(bus.estado_puertas), 0);
    step(2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_door", int'(bus.estado_puertas), 0);
    chk("t5_rst_piso", int'(bus.piso), 0);
    chk("t5_rst_faults", int'({bus.interlock_fault, bus.overtravel_fault, bus.cmd_fault}), 0);
    #1;
    rst_n = 1'b1;

    // Reversal from down to up at floor 2
    repeat (16) step(2'b01, 2'b00, 1'b0);
    chk("t6_piso2", int'(bus.piso), 2);
    npulse = 0;
    repeat (6) begin
      step(2'b10, 2'b00, 1'b0);
      if (bus.cambio_piso) npulse++;
    end
    chk("t6_no_pulse", npulse, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(2'b01, 2'b00, 1'b0);
      n++;
      if (bus.cambio_piso) break;
    end
    chk("t6_reverse_edges", n, 8);
    chk("t6_piso3", int'(bus.piso), 3);

    // Randomized closed loop, checked every cycle by the model
    do_reset();
    rm = 2'b00;
    rp = 2'b00;
    hold_obs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) rm = ($urandom_range(0, 30) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rp = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 40) == 0) ? 2'b11 : 2'($urandom_range(0, 2))) : 2'b00;
      if ($urandom_range(0, 15) == 0) hold_obs = ~hold_obs;
      step(rm, rp, hold_obs);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand_rst_door", int'(bus.estado_puertas), 0);
        #1;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
